// File: rtl/fsm_probe_driver.sv
// Stimulus/check driver for the 4-state Mealy probe FSM: steers the probe to a
// requested state and flags x,y mismatches. Define FSM_DRV_STICKY_ERR_EN for a sticky err with err_clr.
module fsm_probe_driver #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_state,
  output logic                 i,
  output logic                 j,
  input  logic                 x,
  input  logic                 y,
  output logic                 done_valid,
  output logic [1:0]           done_steps,
  output logic [1:0]           cur_state,
  output logic                 err,
`ifdef FSM_DRV_STICKY_ERR_EN
  input  logic                 err_clr,
`endif
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] SA = 2'b00, SB = 2'b01, SC = 2'b10, SD = 2'b11;

  typedef enum logic [1:0] {IDLE, STEP, DONE} drv_t;

  // v = {i,j}
  function automatic logic [1:0] nxt(input logic [1:0] s, input logic [1:0] v);
    case (s)
      SA:      nxt = v[1] ? SB : SA;
      SB:      nxt = v[0] ? SC : SD;
      SC:      nxt = v[1] ? SB : (v[0] ? SC : SD);
      default: nxt = v[1] ? SD : (v[0] ? SC : SA);
    endcase
  endfunction

  function automatic logic [1:0] outxy(input logic [1:0] s, input logic [1:0] v);
    case (s)
      SA:      outxy = v[1] ? 2'b11 : 2'b10;
      SB:      outxy = v[0] ? 2'b01 : 2'b10;
      SC:      outxy = v[1] ? 2'b00 : (v[0] ? 2'b10 : 2'b11);
      default: outxy = v[1] ? 2'b00 : (v[0] ? 2'b10 : 2'b00);
    endcase
  endfunction

  // B has no self-loop, so its park vector lets the probe fall into C
  function automatic logic [1:0] park(input logic [1:0] s);
    case (s)
      SA:      park = 2'b00;
      SB:      park = 2'b01;
      SC:      park = 2'b01;
      default: park = 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] path(input logic [1:0] s, input logic [1:0] t);
    case (t)
      SA:      path = 2'b00;
      SB:      path = (s == SD) ? 2'b01 : 2'b10;
      SC:      path = (s == SA) ? 2'b10 : 2'b01;
      default: path = (s == SA) ? 2'b10 : 2'b00;
    endcase
  endfunction

  drv_t       st, st_n;
  logic [1:0] sh, tgt, tgt_n, steps, steps_n;
  logic [1:0] vec;
  logic       mis;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      st    <= IDLE;
      sh    <= SA;
      tgt   <= SA;
      steps <= 2'd0;
    end else begin
      st    <= st_n;
      sh    <= nxt(sh, vec);
      tgt   <= tgt_n;
      steps <= steps_n;
    end
  end

  always_comb begin
    st_n    = st;
    tgt_n   = tgt;
    steps_n = steps;
    case (st)
      IDLE: if (req_valid) begin
        tgt_n   = req_state;
        steps_n = 2'd0;
        st_n    = STEP;
      end
      STEP: begin
        if (sh == tgt) st_n = DONE;
        else begin
          steps_n = steps + 2'd1;
          if (nxt(sh, path(sh, tgt)) == tgt) st_n = DONE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    vec        = park(sh);
    req_ready  = 1'b0;
    done_valid = 1'b0;
    done_steps = 2'd0;
    case (st)
      IDLE: req_ready = 1'b1;
      STEP: if (sh != tgt) vec = path(sh, tgt);
      default: begin
        done_valid = 1'b1;
        done_steps = steps;
      end
    endcase
  end

  assign {i, j}    = vec;
  assign cur_state = sh;
  assign mis       = ({x, y} != outxy(sh, vec));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) err_count <= '0;
    else if (mis && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
  end

`ifdef FSM_DRV_STICKY_ERR_EN
  logic err_q;
  // a mismatch in the same cycle as err_clr keeps err set
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)        err_q <= 1'b0;
    else if (mis)     err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end
  assign err = mis | err_q;
`else
  assign err = mis;
`endif

endmodule

// File: tb/tb_fsm_probe_driver.sv
// Bench for fsm_probe_driver: behavioural probe FSM, per-cycle vector table,
// plus mismatch/saturation and mid-request reset sequences.
module tb_fsm_probe_driver;

  logic       clk = 1'b0;
  logic       rstN;
  logic       req_valid, req_ready;
  logic [1:0] req_state;
  logic       i, j, x, y;
  logic       done_valid;
  logic [1:0] done_steps, cur_state;
  logic       err;
  logic [7:0] err_count;
  logic       err_clr;
  logic       inv;
  logic [1:0] pst;
  int         nvec = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  fsm_probe_driver #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .i(i), .j(j), .x(x), .y(y),
    .done_valid(done_valid), .done_steps(done_steps), .cur_state(cur_state),
    .err(err),
`ifdef FSM_DRV_STICKY_ERR_EN
    .err_clr(err_clr),
`endif
    .err_count(err_count)
  );

  // Probe model, written straight from the transition/output table
  function automatic logic [1:0] pnext(input logic [1:0] s, input logic ii, input logic jj);
    case (s)
      2'd0:    return ii ? 2'd1 : 2'd0;
      2'd1:    return jj ? 2'd2 : 2'd3;
      2'd2:    return ii ? 2'd1 : (jj ? 2'd2 : 2'd3);
      default: return ii ? 2'd3 : (jj ? 2'd2 : 2'd0);
    endcase
  endfunction

  function automatic logic [1:0] pout(input logic [1:0] s, input logic ii, input logic jj);
    case (s)
      2'd0:    return ii ? 2'b11 : 2'b10;
      2'd1:    return jj ? 2'b01 : 2'b10;
      2'd2:    return ii ? 2'b00 : (jj ? 2'b10 : 2'b11);
      default: return (!ii && jj) ? 2'b10 : 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstN)
    if (!rstN) pst <= 2'd0;
    else       pst <= pnext(pst, i, j);

  logic [1:0] pxy;
  assign pxy = pout(pst, i, j);
  assign x = pxy[1] ^ inv;
  assign y = pxy[0];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rv;
    logic [1:0] rs;
    logic [1:0] ij;
    logic       rdy;
    logic       dn;
    logic [1:0] stp;
    logic [1:0] cur;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rv, input logic [1:0] rs, input logic [1:0] ij,
                     input logic rdy, input logic dn, input logic [1:0] stp, input logic [1:0] cur);
    vec_t v;
    v.rv = rv; v.rs = rs; v.ij = ij; v.rdy = rdy; v.dn = dn; v.stp = stp; v.cur = cur;
    vt.push_back(v);
  endtask

  initial begin
    bit seen;
    rstN = 1'b0; req_valid = 1'b0; req_state = 2'd0; inv = 1'b0; err_clr = 1'b0;

    //   rv rs  ij    rdy dn stp cur
    add(0, 0, 2'b00, 1, 0, 0, 0);   // idle in A
    add(0, 0, 2'b00, 1, 0, 0, 0);
    add(0, 0, 2'b00, 1, 0, 0, 0);
    add(1, 2, 2'b00, 1, 0, 0, 0);   // request C
    add(0, 0, 2'b10, 0, 0, 0, 0);
    add(0, 0, 2'b01, 0, 0, 0, 1);
    add(0, 0, 2'b01, 0, 1, 2, 2);   // done, 2 steps
    add(0, 0, 2'b01, 1, 0, 0, 2);
    add(1, 3, 2'b01, 1, 0, 0, 2);   // request D (1 hop)
    add(0, 0, 2'b00, 0, 0, 0, 2);
    add(0, 0, 2'b10, 0, 1, 1, 3);
    add(1, 1, 2'b10, 1, 0, 0, 3);   // parked in D, request B
    add(0, 0, 2'b01, 0, 0, 0, 3);
    add(0, 0, 2'b10, 0, 0, 0, 2);
    add(0, 0, 2'b01, 0, 1, 2, 1);   // B reached, park 01
    add(1, 2, 2'b01, 1, 0, 0, 2);   // drifted to C; request C (0 hop)
    add(0, 0, 2'b01, 0, 0, 0, 2);
    add(0, 0, 2'b01, 0, 1, 0, 2);
    add(1, 0, 2'b01, 1, 0, 0, 2);   // request A
    add(1, 1, 2'b00, 0, 0, 0, 2);   // req_valid while busy is ignored
    add(1, 1, 2'b00, 0, 0, 0, 3);
    add(0, 0, 2'b00, 0, 1, 2, 0);
    add(0, 0, 2'b00, 1, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_ij", {i, j}, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_steps", done_steps, 0);
    chk("rst_cur", cur_state, 0);
    chk("rst_err", err, 0);
    chk("rst_errcnt", err_count, 0);
    @(negedge clk) rstN = 1'b1;

    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk);
      req_valid = vt[k].rv;
      req_state = vt[k].rs;
      #1;
      chk($sformatf("v%0d_ij", k), {i, j}, vt[k].ij);
      chk($sformatf("v%0d_ready", k), req_ready, vt[k].rdy);
      chk($sformatf("v%0d_done", k), done_valid, vt[k].dn);
      if (vt[k].dn) chk($sformatf("v%0d_steps", k), done_steps, vt[k].stp);
      chk($sformatf("v%0d_cur", k), cur_state, vt[k].cur);
      chk($sformatf("v%0d_err", k), err, 0);
    end
    req_valid = 1'b0;

    // single-cycle mismatch
    @(negedge clk) inv = 1'b1;
    #1 chk("mis1_err", err, 1);
    chk("mis1_cnt_before", err_count, 0);
    @(negedge clk) inv = 1'b0;
    #1 chk("mis1_cnt", err_count, 1);
`ifdef FSM_DRV_STICKY_ERR_EN
    chk("sticky_hold", err, 1);
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    #1 chk("sticky_clr", err, 0);
    chk("sticky_cnt", err_count, 1);
`else
    chk("pulse_end", err, 0);
`endif

    // long mismatch run saturates the counter
    for (int k = 0; k < 300; k++) begin
      @(negedge clk) inv = 1'b1;
      #1 chk("run_err", err, 1);
    end
    @(negedge clk) inv = 1'b0;
    #1 chk("sat_cnt", err_count, 255);
`ifdef FSM_DRV_STICKY_ERR_EN
    chk("sticky_after_run", err, 1);
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    #1 chk("sticky_clr2", err, 0);
`else
    chk("run_end", err, 0);
`endif

    // reset in the middle of an A->D request
    @(negedge clk) begin req_valid = 1'b1; req_state = 2'd3; end
    @(negedge clk) req_valid = 1'b0;
    #1 chk("mid_step_ij", {i, j}, 2'b10);
    chk("mid_step_ready", req_ready, 0);
    rstN = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_ij", {i, j}, 0);
    chk("mid_rst_cur", cur_state, 0);
    chk("mid_rst_done", done_valid, 0);
    chk("mid_rst_cnt", err_count, 0);
    @(negedge clk) rstN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("post_rst_nodone", done_valid, 0);
    end

    @(negedge clk) begin req_valid = 1'b1; req_state = 2'd3; end
    @(negedge clk) req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      #1;
      if (done_valid) begin
        seen = 1'b1;
        chk("ad_steps", done_steps, 2);
        chk("ad_cur", cur_state, 3);
        chk("ad_err", err_count, 0);
      end else @(negedge clk);
    end
    chk("ad_done_seen", seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
